// File: rtl/multichannel_filter_pkg.sv
// Shared constants and elaboration-time helpers for the multichannel input filter.
package multichannel_filter_pkg;

  localparam int unsigned DefChannels  = 10;
  localparam int unsigned DefFilterLen = 4;
  localparam int unsigned DefCntW      = 8;
  localparam int unsigned DefSelW      = 4;

  // Filter counter must hold values 0..filter_len.
  function automatic int unsigned fc_width(input int unsigned filter_len);
    return $clog2(filter_len + 1);
  endfunction

  function automatic longint unsigned cnt_sat(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/multichannel_filter_ch.sv
// One channel: 2-flop synchroniser, glitch filter, polarity, edge pulse and saturating counter.
module multichannel_filter_ch
  import multichannel_filter_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DefFilterLen,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_i,
  input  logic             inv_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             lvl_o,
  output logic             edge_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned      FcW    = fc_width(FILTER_LEN);
  localparam logic [FcW-1:0]   FcLast = FcW'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CntSat = CNT_W'(cnt_sat(CNT_W));

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             state_q, state_d;
  logic             edge_q, edge_d;
  logic [FcW-1:0]   fc_q, fc_d;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic             accept;

  always_comb begin
    s1_d    = in_i;
    s2_d    = s1_q;
    state_d = state_q;
    fc_d    = fc_q;
    accept  = 1'b0;
    if (!en_i) begin
      fc_d = '0;
    end else if (s2_q == state_q) begin
      fc_d = '0;
    end else if (fc_q == FcLast) begin
      state_d = s2_q;
      fc_d    = '0;
      accept  = 1'b1;
    end else begin
      fc_d = fc_q + 1'b1;
    end
    edge_d = accept;

    // A clear coinciding with an edge counts that edge.
    ec_d = ec_q;
    if (clr_i) begin
      ec_d = accept ? CNT_W'(1) : '0;
    end else if (accept && (ec_q != CntSat)) begin
      ec_d = ec_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= 1'b0;
      edge_q  <= 1'b0;
      fc_q    <= '0;
      ec_q    <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      edge_q  <= edge_d;
      fc_q    <= fc_d;
      ec_q    <= ec_d;
    end
  end

  assign lvl_o  = state_q ^ inv_i;
  assign edge_o = edge_q;
  assign cnt_o  = ec_q;

endmodule

// File: rtl/multichannel_filter.sv
// Multichannel input conditioner with shared counter readout.
// Define MULTICHANNEL_FILTER_CHAN_ENABLE_EN to add the per-channel en_i port.
module multichannel_filter
  import multichannel_filter_pkg::*;
#(
  parameter int unsigned CHANNELS   = DefChannels,
  parameter int unsigned FILTER_LEN = DefFilterLen,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned SEL_W      = DefSelW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ii,
  input  logic [CHANNELS-1:0] inv_i,
  input  logic [CHANNELS-1:0] clr_i,
`ifdef MULTICHANNEL_FILTER_CHAN_ENABLE_EN
  input  logic [CHANNELS-1:0] en_i,
`endif
  input  logic [SEL_W-1:0]    sel_i,
  output logic [CHANNELS-1:0] oo,
  output logic [CHANNELS-1:0] edge_o,
  output logic [CNT_W-1:0]    cnt_o
);

  logic [CHANNELS-1:0] en;
  logic [CNT_W-1:0]    ec [CHANNELS];
  logic [CNT_W-1:0]    cnt_q, cnt_d;

`ifdef MULTICHANNEL_FILTER_CHAN_ENABLE_EN
  assign en = en_i;
`else
  assign en = '1;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    multichannel_filter_ch #(
      .FILTER_LEN(FILTER_LEN),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .in_i  (ii[g]),
      .inv_i (inv_i[g]),
      .clr_i (clr_i[g]),
      .en_i  (en[g]),
      .lvl_o (oo[g]),
      .edge_o(edge_o[g]),
      .cnt_o (ec[g])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel_i == SEL_W'(i)) cnt_d = ec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_multichannel_filter.sv
// Scoreboard bench for multichannel_filter: window-based reference model, queued expectations.
module tb_multichannel_filter;

  localparam int unsigned CH   = 10;
  localparam int unsigned FL   = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned SW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  typedef struct {
    logic [CH-1:0] state;
    logic [CH-1:0] edg;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [CH-1:0] ii, inv, clr;
  logic [SW-1:0] sel;
  logic [CH-1:0] oo, edge_o;
  logic [CW-1:0] cnt_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: s2 history delayed by two samples, change accepted when the
  // last FL synchronised samples all disagree with the current level.
  bit          m_state [CH];
  bit          m_p1    [CH];
  bit          m_p2    [CH];
  bit          win     [CH][$];
  int unsigned m_ec    [CH];

  multichannel_filter #(
    .CHANNELS  (CH),
    .FILTER_LEN(FL),
    .CNT_W     (CW),
    .SEL_W     (SW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ii    (ii),
    .inv_i (inv),
    .clr_i (clr),
`ifdef MULTICHANNEL_FILTER_CHAN_ENABLE_EN
    .en_i  ('1),
`endif
    .sel_i (sel),
    .oo    (oo),
    .edge_o(edge_o),
    .cnt_o (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    exp_t e;
    @(posedge clk);
    e.edg = '0;
    if (rst) begin
      e.cnt = '0;
      for (int c = 0; c < CH; c++) begin
        m_state[c] = 1'b0;
        m_p1[c]    = 1'b0;
        m_p2[c]    = 1'b0;
        m_ec[c]    = 0;
        win[c].delete();
      end
    end else begin
      e.cnt = (int'(sel) < CH) ? CW'(m_ec[sel]) : '0;
      for (int c = 0; c < CH; c++) begin
        bit acc;
        win[c].push_back(m_p2[c]);
        if (win[c].size() > FL) void'(win[c].pop_front());
        acc = (win[c].size() == FL);
        foreach (win[c][j]) if (win[c][j] == m_state[c]) acc = 1'b0;
        if (acc) m_state[c] = ~m_state[c];
        e.edg[c] = acc;
        if (clr[c])   m_ec[c] = acc ? 1 : 0;
        else if (acc) m_ec[c] = (m_ec[c] >= CMAX) ? CMAX : m_ec[c] + 1;
        m_p2[c] = m_p1[c];
        m_p1[c] = ii[c];
      end
    end
    for (int c = 0; c < CH; c++) e.state[c] = m_state[c];
    exp_q.push_back(e);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (oo !== (e.state ^ inv)) begin
        errors++;
        $display("FAIL oo: got %h want %h", oo, e.state ^ inv);
      end
      checks++;
      if (edge_o !== e.edg) begin
        errors++;
        $display("FAIL edge_o: got %h want %h", edge_o, e.edg);
      end
      checks++;
      if (cnt_o !== e.cnt) begin
        errors++;
        $display("FAIL cnt_o (sel=%0d): got %0d want %0d", sel, cnt_o, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ii  = '0;
    inv = CH'(1);
    clr = '0;
    sel = '0;

    // Reset with every select value.
    for (int s = 0; s < 16; s++) begin
      sel = SW'(s);
      step();
    end
    rst = 1'b0;
    sel = 3;
    steps(2);

    // Clean rising edge on channel 3.
    ii[3] = 1'b1;
    steps(8);

    // Short glitch on channel 5, then a pulse just long enough for two edges.
    sel   = 5;
    ii[5] = 1'b1;
    steps(3);
    ii[5] = 1'b0;
    steps(8);
    ii[5] = 1'b1;
    steps(4);
    ii[5] = 1'b0;
    steps(10);

    // Saturate channel 0, then clear coincident with the next accepted edge.
    sel = 0;
    for (int t = 0; t < 6; t++) begin
      ii[0] = ~ii[0];
      steps(8);
    end
    ii[0] = ~ii[0];
    steps(5);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    steps(3);

    // Out-of-range select and polarity toggling.
    sel = 12;
    steps(3);
    inv[7] = ~inv[7];
    step();
    inv[7] = ~inv[7];
    steps(2);

    // Randomised traffic with glitches, clears, select changes and resets.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5) == 0)  ii[c]  = ~ii[c];
        clr[c] = ($urandom_range(15) == 0);
        if ($urandom_range(49) == 0) inv[c] = ~inv[c];
      end
      sel = SW'($urandom_range(15));
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    clr = '0;
    steps(4);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multichannel_filter.md
Name: multichannel_filter

Overview:
- Parametrised multi-channel input conditioner, the registered successor to the per-channel inverter arrays in the TMRG test designs.
- Per channel: 2-flop synchroniser, glitch filter, configurable polarity, edge-pulse output and saturating edge counter.
- Counters are read out through a shared channel-select port.
- Sits between asynchronous front-end discriminator outputs and the readout logic; TMRG-triplicated in the final design.

Parameters:
- CHANNELS, 10: number of independent channels (≥1).
- FILTER_LEN, 4: consecutive stable cycles required before a level change is accepted (≥1).
- CNT_W, 8: edge-counter width per channel (≥1).
- SEL_W, 4: channel-select width; must satisfy 2**SEL_W ≥ CHANNELS.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- ii  in  CHANNELS  asynchronous raw inputs.
- inv_i  in  CHANNELS  per-channel polarity invert; quasi-static.
- clr_i  in  CHANNELS  per-channel counter clear; one-cycle pulse.
- sel_i  in  SEL_W  channel select for counter readout.
- oo  out  CHANNELS  filtered level XOR inv_i.
- edge_o  out  CHANNELS  one-cycle pulse on each accepted level change.
- cnt_o  out  CNT_W  registered counter of the selected channel.

Behaviour:
- Reset: sync flops, filtered state, filter counters, edge counters, edge_o and cnt_o all go to 0. oo therefore equals inv_i during and after reset.
- Synchroniser: ii[i] → s1[i] → s2[i], one flop each, no reset bypass.
- Filter counter fc[i] has width $clog2(FILTER_LEN+1).
  - If s2[i]==state[i]: fc←0.
  - Else if fc==FILTER_LEN-1: state←s2, fc←0, edge_o[i]←1 for exactly one cycle.
  - Else: fc←fc+1.
- Latency: if ii[i] changes and is stable before clock edge k, state/oo change after edge k+1+FILTER_LEN.
  - FILTER_LEN=1 gives 2 cycles.
  - A glitch shorter than FILTER_LEN cycles at s2 produces no change and no edge_o.
- Polarity: oo[i] is purely combinational from state and inv_i. Toggling inv_i flips oo immediately; it generates no edge_o and no count.
- Edge counter ec[i], evaluated per clock:
  - clr_i[i] and edge together: ec←1.
  - clr_i[i] alone: ec←0.
  - Edge alone: ec←ec+1, saturating at 2**CNT_W-1 (no wrap).
- Readout: cnt_o←ec[sel_i] each cycle, so cnt_o lags by 1 cycle.
  - sel_i ≥ CHANNELS: cnt_o←0.
  - A same-cycle increment of the selected channel shows one cycle later (cnt_o reflects pre-update ec).
- Reset mid-filter: the pending count is discarded and state returns to 0. No edge_o is generated in the reset cycle or the cycle after it.
- Channels are fully independent; there are no cross-channel interactions except the shared readout mux.

Optional Feature:
- Macro MULTICHANNEL_FILTER_CHAN_ENABLE_EN.
- Defined: adds input port en_i[CHANNELS].
  - en_i[i]=0: state[i] frozen, fc[i] held at 0, edge_o[i]=0, ec[i] frozen; clr_i still clears ec.
  - On re-enable, filtering restarts from the frozen state. A changed input needs the full FILTER_LEN cycles again.
- Undefined: en_i port does not exist; all channels are always enabled.

Decomposition:
- Package multichannel_filter_pkg holds:
  - localparam-computing function for the fc width (clog2).
  - Default parameter constants.
  - Saturation value constant function for CNT_W.
- Sub-module multichannel_filter_ch contains one channel's sync, filter, edge and counter logic. The top instantiates CHANNELS copies in a generate loop, each copy with its own instance-local registers, and adds the readout mux and cnt_o register.

Test Plan:
- Reset, FILTER_LEN=4, inv_i=0x001: oo==0x001, edge_o==0, cnt_o==0 for sel_i=0..15.
- ii[3] 0→1 held, stable before edge k: oo[3]=1 after edge k+5; edge_o[3] high exactly one cycle. With sel_i=3, cnt_o==1 one cycle later.
- ii[5] glitch high for 3 cycles, FILTER_LEN=4: no change on oo[5] or edge_o[5]; ec[5] stays 0. A 4-cycle pulse gives two edges, ec[5]==2.
- CNT_W=2, toggle ii[0] 6 times with adequate spacing: cnt_o saturates at 3. Then clr_i[0] pulse coincident with a 7th edge: cnt_o==1.
- sel_i=12 with CHANNELS=10: cnt_o==0. Toggling inv_i[7] flips oo[7] same cycle with edge_o==0.
- Macro defined, en_i[2]=0, ii[2] toggles for 20 cycles: oo[2], edge_o[2], ec[2] unchanged. Re-enable: change accepted FILTER_LEN cycles later.
